ex_mem_register: RTL

//  - Pipeline register between the execute stage and the memory stage.
//  - Captures the ALU result, store data, memory/writeback controls and the destination register from EX.
//  - Presents them to the memory stage.
//  - Valid/ready handshake on both sides, synchronous flush, and a forwarding tap for EX operand bypass.

---
 rtl/ex_mem_register.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ex_mem_register.sv
// ex_mem_register: EX -> MEM pipeline register.
// Holds the ALU result, store data, memory/writeback controls and destination
// register of one instruction. It uses valid/ready handshakes on both sides,
// supports a synchronous flush, and exposes a forwarding tap for EX operand
// bypass.
//
// Optional feature: define EX_MEM_SKID_EN to add a second (skid) entry.
// ex_ready then comes straight from a flop and has no combinational path
// from mem_ready. With the macro undefined the register holds a single entry.
module ex_mem_register #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [DATA_W-1:0]     ex_alu_data,
    input  logic [DATA_W-1:0]     ex_write_data,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic [DATA_W-1:0]     read_add,
    output logic [DATA_W-1:0]     write_data,
    output logic [DATA_W-1:0]     alu_data,
    output logic [REG_ADDR_W-1:0] rd,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]     fwd_data
);

    typedef struct packed {
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     wd;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
    } entry_t;

    entry_t w_in;
    entry_t r_main;
    logic   r_main_valid;
    logic   w_accept;
    logic   w_drain;

    // Incoming EX fields, bundled so entries move as one unit
    always_comb begin
        w_in            = '0;
        w_in.alu        = ex_alu_data;
        w_in.wd         = ex_write_data;
        w_in.mem_read   = ex_mem_read;
        w_in.mem_write  = ex_mem_write;
        w_in.mem_to_reg = ex_mem_to_reg;
        w_in.reg_write  = ex_reg_write;
        w_in.rd         = ex_rd;
    end

    assign w_drain = r_main_valid & mem_ready;

`ifdef EX_MEM_SKID_EN
    entry_t r_skid;
    logic   r_skid_valid;

    // Ready depends only on skid occupancy, so the upstream timing path is a
    // single flop.
    assign ex_ready = !r_skid_valid;
    assign w_accept = ex_valid & !r_skid_valid;

    // Two-entry FIFO. Main is the output entry and skid catches one
    // instruction that arrives while main is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            // Squash both entries. Data may stay stale because every
            // consumer-visible control is gated by valid.
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_main_valid) begin
            if (w_drain) begin
                if (r_skid_valid) begin
                    r_main       <= r_skid;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_main <= w_in;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid       <= w_in;
                r_skid_valid <= 1'b1;
            end
        end else if (w_accept) begin
            r_main       <= w_in;
            r_main_valid <= 1'b1;
        end
    end
`else
    // A new entry fits when the register is empty or is emptying this cycle.
    assign ex_ready = !r_main_valid | mem_ready;
    assign w_accept = ex_valid & ex_ready;

    // Single-entry register. Flush beats accept and drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
        end else if (w_accept) begin
            r_main       <= w_in;
            r_main_valid <= 1'b1;
        end else if (w_drain) begin
            r_main_valid <= 1'b0;
        end
    end
`endif

    // Controls that touch memory or the register file are qualified by
    // valid, so a bubble is harmless.
    logic [2:0] w_ctrl_raw;
    logic [2:0] w_ctrl_gated;
    assign w_ctrl_raw = {r_main.mem_read, r_main.mem_write, r_main.reg_write};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_gate
            assign w_ctrl_gated[gi] = w_ctrl_raw[gi] & r_main_valid;
        end
    endgenerate

    assign mem_valid  = r_main_valid;
    assign mem_read   = w_ctrl_gated[2];
    assign mem_write  = w_ctrl_gated[1];
    assign reg_write  = w_ctrl_gated[0];
    assign mem_to_reg = r_main.mem_to_reg;
    assign read_add   = r_main.alu;
    assign alu_data   = r_main.alu;
    assign write_data = r_main.wd;
    assign rd         = r_main.rd;

    // Only ALU results can be bypassed. A load's value is not known yet.
    assign fwd_valid = w_ctrl_gated[0] & !r_main.mem_to_reg;
    assign fwd_rd    = r_main.rd;
    assign fwd_data  = r_main.alu;

endmodule
